// File: rtl/sample_ram_pkg.sv
// sample_ram_pkg: shared widths, parameter defaults and FSM encoding for the sample RAM responder.
package sample_ram_pkg;
    localparam int DATA_W          = 16;
    localparam int ADDR_W          = 26;
    localparam int DEF_DEPTH_LOG2  = 14;
    localparam int DEF_READ_LAT    = 4;
    localparam int DEF_INIT_CYCLES = 16;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RD_WAIT, ST_RD_PRES} state_t;
endpackage

// File: rtl/sample_ram_array.sv
// sample_ram_array: single-port synchronous RAM with registered read (read-before-write), no reset.
module sample_ram_array #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/sample_ram_responder.sv
// sample_ram_responder: command FSM in front of a sample RAM with fixed read latency.
// Optional SAMPLE_RAM_BOUNDS_EN drops out-of-range accesses and adds a sticky err output.
module sample_ram_responder
    import sample_ram_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int READ_LAT    = DEF_READ_LAT,
    parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_enable,
    input  logic              read_request,
    input  logic              read_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_data_pres,
    output logic              rdy,
    output logic [ADDR_W-1:0] max_ram_address
`ifdef SAMPLE_RAM_BOUNDS_EN
    ,
    output logic              err
`endif
);
    localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'((64'd1 << DEPTH_LOG2) - 64'd1);
    localparam logic [15:0]       INIT_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [15:0]       RD_LAST   = 16'(READ_LAT);

    state_t                r_state, w_state_nxt;
    logic [15:0]           r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     w_addr_sel;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_oob, w_we, w_rd_start, w_load;

    // The RAM sees the live address while idle, the latched one during a read.
    assign w_addr_sel      = (r_state == ST_IDLE) ? address : r_addr;
    assign rdy             = (r_state != ST_INIT);
    assign max_ram_address = MAX_ADDR;
`ifdef SAMPLE_RAM_BOUNDS_EN
    assign w_oob = (w_addr_sel > MAX_ADDR);
`else
    logic w_unused;
    assign w_oob    = 1'b0;
    assign w_unused = ^w_addr_sel[ADDR_W-1:DEPTH_LOG2];
`endif

    sample_ram_array #(.AW(DEPTH_LOG2), .DW(DATA_W)) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (w_addr_sel[DEPTH_LOG2-1:0]),
        .i_wdata(data_in),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_rd_start  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_INIT:    w_state_nxt = (r_cnt == INIT_LAST) ? ST_IDLE : ST_INIT;
            ST_IDLE: begin
                w_we        = write_enable && !w_oob;
                w_rd_start  = read_request && !write_enable;
                w_state_nxt = w_rd_start ? ST_RD_WAIT : ST_IDLE;
            end
            ST_RD_WAIT: begin
                w_load      = (r_cnt == RD_LAST);
                w_state_nxt = w_load ? ST_RD_PRES : ST_RD_WAIT;
            end
            ST_RD_PRES: w_state_nxt = (read_ack && rd_data_pres) ? ST_IDLE : ST_RD_PRES;
            default:    w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            rd_data_pres <= 1'b0;
            data_out     <= '0;
`ifdef SAMPLE_RAM_BOUNDS_EN
            err          <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 16'd1;
            if (w_rd_start) r_addr <= address;
            if (w_load) begin
                data_out     <= w_oob ? '0 : w_rdata;
                rd_data_pres <= 1'b1;
            end else if (r_state == ST_RD_PRES && read_ack) begin
                rd_data_pres <= 1'b0;
            end
`ifdef SAMPLE_RAM_BOUNDS_EN
            if (r_state == ST_IDLE && (write_enable || read_request) && w_oob) err <= 1'b1;
`endif
        end
    end
endmodule
